jump_physics: RTL

Parametrised vertical-motion engine for the runner sprite, replacing the fixed-table jump controller. It holds the sprite's Y position and a signed velocity. On each frame `update` strobe it integrates velocity into position under constant gravity, with a terminal fall speed, a ceiling clamp and a ground clamp. It sits between the keyboard/command decoder (`operation`) and the sprite drawer (`yout`) and emits landing and acceptance pulses for the game-control FSM.

---
 rtl/jump_physics_if.sv | 30 +++
 rtl/jump_physics.sv | 120 ++++++++++++
 2 files changed

// File: rtl/jump_physics_if.sv
//------------------------------------------------------------------------------
// jump_physics_if : command/update strobe in, sprite Y/velocity/status out
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface jump_physics_if #(
  parameter int Y_W = 7
) ();
  logic                update;
  logic [2:0]          operation;
  logic [Y_W-1:0]      yout;
  logic signed [Y_W:0] vel;
  logic                airborne;
  logic                landed;
  logic                cmd_ack;

  modport master (
    output update, operation,
    input  yout, vel, airborne, landed, cmd_ack
  );

  modport slave (
    input  update, operation,
    output yout, vel, airborne, landed, cmd_ack
  );
endinterface

`default_nettype wire

// File: rtl/jump_physics.sv
//------------------------------------------------------------------------------
// jump_physics : vertical-motion engine (gravity, terminal speed, ceiling/ground)
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module jump_physics #(
  parameter int Y_W     = 7,
  parameter int GROUND  = 108,
  parameter int CEIL    = 0,
  parameter int BIG_V   = 9,
  parameter int SMALL_V = 7,
  parameter int GRAVITY = 1,
  parameter int V_MAX   = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  jump_physics_if.slave bus
);

  localparam int VW = Y_W + 2;

  localparam logic signed [VW-1:0] C_GROUND    = VW'(GROUND);
  localparam logic signed [VW-1:0] C_CEIL      = VW'(CEIL);
  localparam logic signed [VW-1:0] C_BIG_NEG   = VW'(-BIG_V);
  localparam logic signed [VW-1:0] C_SMALL_NEG = VW'(-SMALL_V);
  localparam logic signed [VW-1:0] C_VMAX      = VW'(V_MAX);
  localparam logic signed [VW-1:0] C_GRAV      = VW'(GRAVITY);

  typedef enum logic [0:0] {
    ST_GROUND = 1'b0,
    ST_AIR    = 1'b1
  } state_t;

  state_t              r_state;
  logic [Y_W-1:0]      r_y;
  logic signed [Y_W:0] r_vel;
  logic                r_landed;
  logic                r_ack;

  logic                w_jump_big;
  logic                w_jump_small;
  logic                w_drop;
  logic                w_accept;
  logic                w_step;
  logic                w_land;
  logic                w_ceil;
  logic signed [VW-1:0] w_v;
  logic signed [VW-1:0] w_yn;
  logic signed [VW-1:0] w_vg;
  logic signed [Y_W:0]  w_vnext;

  always_comb begin
    w_jump_big   = (r_state == ST_GROUND) && (bus.operation == 3'b001);
    w_jump_small = (r_state == ST_GROUND) && (bus.operation == 3'b010);
    w_drop       = (r_state == ST_AIR)    && (bus.operation == 3'b100);
    w_accept     = w_jump_big || w_jump_small || w_drop;

    // Velocity for this edge: a command accepted now takes effect before the step.
    if (w_jump_big) begin
      w_v = C_BIG_NEG;
    end else if (w_jump_small) begin
      w_v = C_SMALL_NEG;
    end else if (w_drop) begin
      w_v = C_VMAX;
    end else begin
      w_v = {r_vel[Y_W], r_vel};
    end

    w_step = bus.update && ((r_state == ST_AIR) || w_accept);
    w_yn   = $signed({2'b00, r_y}) + w_v;
    w_land = w_step && (w_yn >= C_GROUND);
    // Clamp only while still rising; resting at the ceiling with zero velocity
    // must be allowed to fall away, otherwise the sprite would stick forever.
    w_ceil = w_step && !w_land && (w_yn <= C_CEIL) && w_v[VW-1];

    w_vg    = w_v + C_GRAV;
    w_vnext = (w_vg > C_VMAX) ? C_VMAX[Y_W:0] : w_vg[Y_W:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_GROUND;
      r_y      <= Y_W'(GROUND);
      r_vel    <= '0;
      r_landed <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_landed <= w_land;
      // A fast-fall that lands on the same edge reports only the landing.
      r_ack    <= w_accept && !w_land;
      if (w_land) begin
        r_state <= ST_GROUND;
        r_y     <= Y_W'(GROUND);
        r_vel   <= '0;
      end else if (w_ceil) begin
        r_state <= ST_AIR;
        r_y     <= Y_W'(CEIL);
        r_vel   <= '0;
      end else if (w_step) begin
        r_state <= ST_AIR;
        r_y     <= w_yn[Y_W-1:0];
        r_vel   <= w_vnext;
      end else if (w_accept) begin
        r_state <= ST_AIR;
        r_vel   <= w_v[Y_W:0];
      end
    end
  end

  assign bus.yout     = r_y;
  assign bus.vel      = r_vel;
  assign bus.airborne = (r_state == ST_AIR);
  assign bus.landed   = r_landed;
  assign bus.cmd_ack  = r_ack;

endmodule

`default_nettype wire
